// File: rtl/wasm_frame_alloc.sv
// wasm_frame_alloc: call-frame allocator that moves params into locals, zero-fills declared locals and releases frames on return
package wasm_frame_alloc_pkg;
  typedef logic [7:0] valtype_t;
  localparam valtype_t VT_I32 = 8'h7f;
  localparam valtype_t VT_I64 = 8'h7e;
  localparam valtype_t VT_F32 = 8'h7d;
  localparam valtype_t VT_F64 = 8'h7c;
  typedef struct packed {
    valtype_t    vtype;
    logic [63:0] value;
  } stack_entry_t;
endpackage

module wasm_frame_alloc
  import wasm_frame_alloc_pkg::*;
#(
  parameter int MAX_DEPTH  = 8,
  parameter int MAX_FRAME  = 32,
  parameter int MAX_LOCALS = MAX_FRAME * MAX_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         call_valid,
  output logic         call_ready,
  input  logic [7:0]   call_nparams,
  input  logic [7:0]   call_nlocals,
  input  logic         ret_valid,
  output logic [7:0]   type_idx,
  input  valtype_t     type_data,
  output logic         pop_req,
  input  logic         pop_valid,
  input  stack_entry_t pop_data,
  output logic         lw_en,
  output logic [15:0]  lw_base,
  output logic [7:0]   lw_idx,
  output stack_entry_t lw_data,
  output logic [15:0]  cur_base,
  output logic [7:0]   depth,
  output logic         busy,
  output logic         done,
  output logic         trap
);
  localparam int AW = MAX_DEPTH > 1 ? $clog2(MAX_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, PARAM, ZERO, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] next_free;
  logic [7:0] np, nl, k, j, depth_m1;
  logic [15:0] frames [MAX_DEPTH];
  logic [16:0] end_sum;
  logic call_bad, accept, ret_go, trap_q;
  assign end_sum = {1'b0, next_free} + {9'b0, call_nlocals};
  assign call_bad = (32'(depth) == MAX_DEPTH) || (32'(end_sum) > MAX_LOCALS) ||
                    (32'(call_nlocals) > MAX_FRAME) || (call_nparams > call_nlocals);
  assign accept = state == IDLE && call_valid && !ret_valid && !call_bad;
  assign ret_go = state == IDLE && ret_valid && depth != 8'd0;
  assign depth_m1 = depth - 8'd1;
  assign trap = trap_q;
  // state register; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state and all handshake/write-port outputs
  always_comb begin
    state_nx = state;
    call_ready = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    pop_req = 1'b0;
    lw_en = 1'b0;
    lw_base = '0;
    lw_idx = '0;
    lw_data = '0;
    type_idx = '0;
    case (state)
      IDLE: begin
        call_ready = 1'b1;
        if (accept) state_nx = call_nparams != 8'd0 ? PARAM : call_nlocals != 8'd0 ? ZERO : DONE;
      end
      PARAM: begin
        busy = 1'b1;
        pop_req = 1'b1;
        lw_en = pop_valid;
        lw_base = cur_base;
        lw_idx = k;
        lw_data = pop_valid ? pop_data : '0;
        if (pop_valid && k == 8'd0) state_nx = nl > np ? ZERO : DONE;
      end
      ZERO: begin
        busy = 1'b1;
        type_idx = j;
        lw_en = 1'b1;
        lw_base = cur_base;
        lw_idx = j;
        lw_data = '{vtype: type_data, value: 64'h0};
        if (j == nl - 8'd1) state_nx = DONE;
      end
      default: begin
        done = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end
  // saved caller bases; only written on an accepted call so no reset needed
  always_ff @(posedge clk)
    if (accept) frames[depth[AW-1:0]] <= cur_base;
  // frame bookkeeping, sequence counters and trap pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur_base <= '0;
      next_free <= '0;
      depth <= '0;
      np <= '0;
      nl <= '0;
      k <= '0;
      j <= '0;
      trap_q <= 1'b0;
    end else begin
      trap_q <= state == IDLE && (ret_valid ? depth == 8'd0 : call_valid && call_bad);
      if (ret_go) begin
        next_free <= cur_base;
        cur_base <= frames[depth_m1[AW-1:0]];
        depth <= depth_m1;
      end else if (accept) begin
        cur_base <= next_free;
        next_free <= end_sum[15:0];
        depth <= depth + 8'd1;
        np <= call_nparams;
        nl <= call_nlocals;
        k <= call_nparams - 8'd1;
        j <= call_nparams;
      end else if (state == PARAM && pop_valid) k <= k - 8'd1;
      else if (state == ZERO) j <= j + 8'd1;
    end
endmodule

// File: tb/tb_wasm_frame_alloc.sv
// tb_wasm_frame_alloc: directed self-checking bench for the call-frame allocator
module tb_wasm_frame_alloc;
  import wasm_frame_alloc_pkg::*;
  typedef struct packed {
    logic [15:0]  b;
    logic [7:0]   i;
    stack_entry_t d;
  } wr_t;
  logic clk = 0, rst_n = 0;
  logic call_valid = 0, ret_valid = 0, pop_valid = 0;
  logic [7:0] call_nparams = 0, call_nlocals = 0;
  stack_entry_t pop_data = '0;
  logic call_ready, pop_req, lw_en, busy, done, trap;
  logic [7:0] type_idx, lw_idx, depth;
  logic [15:0] lw_base, cur_base;
  stack_entry_t lw_data;
  valtype_t type_data;
  valtype_t types [32];
  stack_entry_t pop_vals [4];
  wr_t wq [$];
  int checks = 0, errors = 0, lat;

  wasm_frame_alloc #(.MAX_DEPTH(3), .MAX_FRAME(32), .MAX_LOCALS(20)) dut (
    .clk(clk), .rst_n(rst_n), .call_valid(call_valid), .call_ready(call_ready),
    .call_nparams(call_nparams), .call_nlocals(call_nlocals), .ret_valid(ret_valid),
    .type_idx(type_idx), .type_data(type_data), .pop_req(pop_req), .pop_valid(pop_valid),
    .pop_data(pop_data), .lw_en(lw_en), .lw_base(lw_base), .lw_idx(lw_idx), .lw_data(lw_data),
    .cur_base(cur_base), .depth(depth), .busy(busy), .done(done), .trap(trap)
  );

  always #5 clk = ~clk;
  assign type_data = types[type_idx[4:0]];

  always @(negedge clk) if (lw_en) wq.push_back('{b: lw_base, i: lw_idx, d: lw_data});

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_call(input logic [7:0] np, input logic [7:0] nl, input int dly, output int n);
    int pi = 0, w = 0;
    n = 0;
    call_valid = 1; call_nparams = np; call_nlocals = nl;
    tick;
    call_valid = 0;
    while (!done && n < 100) begin
      if (pop_req && pi < int'(np)) begin
        if (w == dly) begin
          pop_valid = 1; pop_data = pop_vals[pi]; pi++; w = 0;
        end else begin
          pop_valid = 0; w++;
        end
      end else pop_valid = 0;
      tick;
      n++;
    end
    pop_valid = 0;
    if (n >= 100) chk("done_timeout", 96'(n), 96'(0));
    tick;
  endtask

  task automatic do_trap_call(input logic [7:0] np, input logic [7:0] nl, input string tag);
    call_valid = 1; call_nparams = np; call_nlocals = nl;
    tick;
    call_valid = 0;
    chk({tag, "_trap"}, 96'(trap), 96'(1));
    chk({tag, "_busy"}, 96'(busy), 96'(0));
    tick;
    chk({tag, "_trap_clr"}, 96'(trap), 96'(0));
  endtask

  task automatic do_ret;
    ret_valid = 1;
    tick;
    ret_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) types[i] = VT_I32;
    types[2] = VT_I64;
    types[3] = VT_F32;
    #12;
    chk("rst_ready", 96'(call_ready), 96'(1));
    chk("rst_flags", 96'({busy, done, trap, pop_req, lw_en}), 96'(0));
    chk("rst_base_depth", 96'({cur_base, depth}), 96'(0));
    chk("rst_wport", 96'({type_idx, lw_base, lw_idx, lw_data}), 96'(0));
    @(posedge clk); #1 rst_n = 1;
    tick;

    pop_vals[0] = '{vtype: VT_I32, value: 64'h1111};
    pop_vals[1] = '{vtype: VT_F64, value: 64'h2222};
    wq.delete();
    do_call(8'd2, 8'd4, 0, lat);
    chk("c1_lat", 96'(lat), 96'(4));
    chk("c1_nw", 96'(wq.size()), 96'(4));
    if (wq.size() == 4) begin
      chk("c1_w0", wq[0], {16'd0, 8'd1, VT_I32, 64'h1111});
      chk("c1_w1", wq[1], {16'd0, 8'd0, VT_F64, 64'h2222});
      chk("c1_w2", wq[2], {16'd0, 8'd2, VT_I64, 64'h0});
      chk("c1_w3", wq[3], {16'd0, 8'd3, VT_F32, 64'h0});
    end
    chk("c1_base_depth", 96'({cur_base, depth}), {80'd0, 8'd0, 8'd1});
    chk("c1_ready", 96'({call_ready, busy}), 96'(2'b10));

    wq.delete();
    do_call(8'd0, 8'd3, 0, lat);
    chk("c2_lat", 96'(lat), 96'(3));
    chk("c2_base_depth", 96'({cur_base, depth}), 96'({16'd4, 8'd2}));
    chk("c2_nw", 96'(wq.size()), 96'(3));
    if (wq.size() == 3) chk("c2_w2", wq[2], {16'd4, 8'd2, VT_I64, 64'h0});
    do_ret;
    chk("r1_base_depth", 96'({cur_base, depth}), 96'({16'd0, 8'd1}));

    pop_vals[0] = '{vtype: VT_I64, value: 64'hc};
    pop_vals[1] = '{vtype: VT_F32, value: 64'hd};
    wq.delete();
    do_call(8'd2, 8'd2, 3, lat);
    chk("c3_lat", 96'(lat), 96'(8));
    chk("c3_base_depth", 96'({cur_base, depth}), 96'({16'd4, 8'd2}));
    chk("c3_nw", 96'(wq.size()), 96'(2));
    if (wq.size() == 2) begin
      chk("c3_w0", wq[0], {16'd4, 8'd1, VT_I64, 64'hc});
      chk("c3_w1", wq[1], {16'd4, 8'd0, VT_F32, 64'hd});
    end

    wq.delete();
    do_call(8'd0, 8'd0, 0, lat);
    chk("c4_lat", 96'(lat), 96'(0));
    chk("c4_nw", 96'(wq.size()), 96'(0));
    chk("c4_base_depth", 96'({cur_base, depth}), 96'({16'd6, 8'd3}));

    wq.delete();
    do_trap_call(8'd0, 8'd1, "full");
    chk("full_base_depth", 96'({cur_base, depth}), 96'({16'd6, 8'd3}));
    do_ret;
    chk("r2_base_depth", 96'({cur_base, depth}), 96'({16'd4, 8'd2}));
    do_trap_call(8'd0, 8'd15, "ovf");
    do_trap_call(8'd3, 8'd2, "np_gt_nl");
    chk("ovf_base_depth", 96'({cur_base, depth}), 96'({16'd4, 8'd2}));
    chk("trap_nw", 96'(wq.size()), 96'(0));

    do_call(8'd0, 8'd14, 0, lat);
    chk("fit_lat", 96'(lat), 96'(14));
    chk("fit_base_depth", 96'({cur_base, depth}), 96'({16'd6, 8'd3}));
    do_ret;
    chk("r3_base_depth", 96'({cur_base, depth}), 96'({16'd4, 8'd2}));

    call_valid = 1; call_nparams = 0; call_nlocals = 1; ret_valid = 1;
    tick;
    call_valid = 0; ret_valid = 0;
    chk("both_base_depth", 96'({cur_base, depth}), 96'({16'd0, 8'd1}));
    chk("both_busy", 96'({busy, trap}), 96'(0));
    do_ret;
    chk("r4_base_depth", 96'({cur_base, depth}), 96'(0));
    do_ret;
    chk("r0_trap", 96'(trap), 96'(1));
    chk("r0_depth", 96'(depth), 96'(0));

    do_call(8'd0, 8'd2, 0, lat);
    call_valid = 1; call_nparams = 0; call_nlocals = 5;
    tick;
    call_valid = 0;
    tick;
    chk("rz_pre_base", 96'({cur_base, depth, lw_en}), 96'({16'd2, 8'd2, 1'b1}));
    rst_n = 0;
    #1;
    chk("rz_flags", 96'({call_ready, busy, done, trap, pop_req, lw_en}), 96'(6'b100000));
    chk("rz_base_depth", 96'({cur_base, depth}), 96'(0));
    chk("rz_wport", 96'({type_idx, lw_base, lw_idx, lw_data}), 96'(0));
    @(posedge clk); #1 rst_n = 1;
    tick;
    wq.delete();
    do_call(8'd0, 8'd1, 0, lat);
    chk("rz_next_base", 96'({cur_base, depth}), 96'({16'd0, 8'd1}));
    chk("rz_nw", 96'(wq.size()), 96'(1));
    if (wq.size() == 1) chk("rz_w0", wq[0], {16'd0, 8'd0, VT_I32, 64'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wasm_frame_alloc.md
Name: wasm_frame_alloc

Overview:
- Call-frame allocator and local-variable initialiser. It drives the write port of the locals store on function entry and releases frames on return.
- On a call it allocates a contiguous locals window and moves parameters from the operand stack into locals. It then zero-fills the declared (non-parameter) locals with their types and exposes the current frame base to the execute stage.
- It sits between the control unit (call/return requests), the operand stack (pop port) and the locals store (single-write port).

Parameters:
- MAX_LOCALS, LOCAL_COUNT*CALL_STACK_DEPTH, total locals slots in the locals store.
- MAX_DEPTH, CALL_STACK_DEPTH, frame-stack entries.
- MAX_FRAME, 32, maximum locals per function (params + declared).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- call_valid  in  1  call request
- call_ready  out  1  allocator idle and able to accept
- call_nparams  in  8  parameter count
- call_nlocals  in  8  total locals including params
- ret_valid  in  1  return request (single-cycle accept when idle)
- type_idx  out  8  local index being initialised
- type_data  in  valtype_t  type of local type_idx (combinational lookup)
- pop_req  out  1  operand-stack pop request
- pop_valid  in  1  pop data valid this cycle
- pop_data  in  stack_entry_t  popped entry
- lw_en  out  1  locals write enable
- lw_base  out  16  write base
- lw_idx  out  8  write local index
- lw_data  out  stack_entry_t  write data
- cur_base  out  16  base of active frame
- depth  out  8  live frames
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, frame ready
- trap  out  1  one-cycle pulse, call rejected

Behaviour:
- Reset: FSM=IDLE.
  - cur_base=0, next_free=0, depth=0.
  - call_ready=1; busy, done, trap, pop_req and lw_en all 0.
  - type_idx, lw_base, lw_idx and lw_data all 0.
- States: IDLE, PARAM, ZERO, DONE.
- IDLE, call_valid=1 (call_ready=1), new base nb=next_free:
  - If depth==MAX_DEPTH, or nb+call_nlocals>MAX_LOCALS, or call_nlocals>MAX_FRAME, or call_nparams>call_nlocals: pulse trap next cycle and stay IDLE. No state change.
  - Otherwise: push cur_base onto the frame stack, cur_base<=nb, next_free<=nb+nlocals, depth++, latch counts, busy=1, call_ready=0.
  - Then go to PARAM if nparams>0, else ZERO if nlocals>0, else DONE.
- PARAM:
  - k counts down from nparams-1 to 0 (the last argument is on top of the stack).
  - pop_req=1 held until pop_valid.
  - On pop_valid, in the same cycle: lw_en=1, lw_base=cur_base, lw_idx=k, lw_data=pop_data.
  - After k==0, go to ZERO if nlocals>nparams, else DONE.
  - pop_valid with pop_req=0 is ignored.
- ZERO:
  - j ascends from nparams to nlocals-1, one write per cycle, no stalls.
  - type_idx=j; lw_en=1, lw_idx=j, lw_data={vtype:type_data, value:64'h0}.
  - After j==nlocals-1, go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE with call_ready=1.
- Call latency: 1 (accept) + params (each ≥1 cycle) + declared locals + 1 (DONE).
- Return, IDLE only:
  - ret_valid with depth>0: next_free<=cur_base, cur_base<=popped base, depth--. Completes in one cycle; no writes issued.
  - ret_valid with depth==0: trap pulse, no state change.
  - ret_valid while busy is ignored.
- Simultaneous call_valid and ret_valid in IDLE: return wins, call is not accepted that cycle.
- Widths: all address sums are computed at 17 bits before comparing with MAX_LOCALS, so they never wrap.
- Asynchronous reset mid-sequence aborts immediately to reset values. Partially written locals are left as-is.

Test Plan:
- Call nparams=2, nlocals=4 from reset; stack pops A then B; types[2]=i64, types[3]=f32 -> writes idx1=A, idx0=B, idx2={i64,0}, idx3={f32,0} at base 0; done pulses; cur_base=0, depth=1, next_free=4.
- Nested call nparams=0, nlocals=3 after the first -> cur_base=4, depth=2. Return -> cur_base=0, depth=1, next_free=4.
- pop_valid delayed 3 cycles per param -> pop_req held, exactly one write per pop, no extra writes.
- Depth at MAX_DEPTH, or nlocals overflowing MAX_LOCALS -> trap pulse, cur_base/depth/next_free unchanged, lw_en never asserted.
- Call nlocals=0 -> done two cycles after accept, no writes. ret_valid with depth 0 -> trap.
- Reset asserted during ZERO -> all outputs at reset values the same cycle; next call allocates base 0.
